data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//   Multi-cycle data-memory stage for the 8-bit datapath. Accepts load/store
//   requests from the control unit, models a fixed wait-state memory, and
//   holds the last loaded byte on rdata, which drives the mem_data input of
//   the A/B operand muxes (sel=11). Stores take their data from the ALU result.
// PARAMETERS
//   DATA_W       8    data width in bits
//   ADDR_W       8    address width in bits
//   DEPTH        256  implemented words; DEPTH <= 2**ADDR_W
//   WAIT_CYCLES  1    extra wait states before the access edge (0..15)
// PORTS
//   clk     in   1       system clock, rising edge
//   rst_n   in   1       asynchronous active-low reset
//   req     in   1       request strobe, sampled only in IDLE
//   we      in   1       1 = store, 0 = load (sampled with req)
//   addr    in   ADDR_W  byte address (sampled with req)
//   wdata   in   DATA_W  store data (sampled with req)
//   busy    out  1       1 while a request is in flight
//   done    out  1       one-cycle pulse: access completed
//   err     out  1       one-cycle pulse with done: addr >= DEPTH
//   rdata   out  DATA_W  last loaded byte; held until the next successful load
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, busy=0, done=0, err=0, rdata=0,
//     counter=0, latched addr/we/wdata=0. Memory array is NOT reset.
//   FSM states: IDLE, ACCESS.
//   IDLE: on edge with req=1 -> latch addr/we/wdata, cnt<=WAIT_CYCLES,
//     state<=ACCESS, busy<=1. req=0 -> stay.
//   ACCESS: edge with cnt!=0 -> cnt<=cnt-1. Edge with cnt==0 -> perform
//     access, state<=IDLE, busy<=0, done<=1 (err<=1 if out of range).
//   Access: store writes wdata to mem[addr]; rdata unchanged. Load sets
//     rdata<=mem[addr]. Out of range (addr>=DEPTH): no write, rdata
//     unchanged, err pulses with done.
//   Latency: done high WAIT_CYCLES+1 cycles after the accepting edge.
//   done/err are high exactly one cycle; cleared on every other edge.
//   req while busy=1: ignored, not queued; latched fields unaffected.
//   Back-to-back: req=1 in the cycle done=1 is accepted (state is IDLE);
//     busy returns to 1 on that edge.
//   Write then immediate read of same address returns the new value.
//   Reset mid-ACCESS: request aborted; a store not yet at its access edge
//     never writes; done/err not generated.
//   Address compare uses full ADDR_W bits; no wrap-around.
// TESTING
//   1 Assert rst_n=0 mid-run -> busy=0, done=0, err=0, rdata=8'h00 at once.
//   2 WAIT_CYCLES=1: store 0x5A@0x10, then load 0x10 -> each done 2 cycles
//     after accept; rdata=0x5A after load; rdata unchanged after store.
//   3 Hold req=1 across a request with addr changing 0x10->0x20 while busy
//     -> only one done; then load 0x20 returns its own contents.
//   4 Back-to-back: store 0x33@0x01 then req on done cycle load 0x01 ->
//     second done 2 cycles later, rdata=0x33.
//   5 DEPTH=128: store 0xFF@0x80 -> done=err=1 one cycle; load 0x00
//     unchanged, rdata unchanged.
//   6 Store 0x77@0x05 with rst_n pulsed low in ACCESS before access edge
//     -> no done; later load 0x05 does not return 0x77 (preloaded 0x00).

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory stage: accepts one load/store at a time, waits WAIT_CYCLES
// extra cycles, then performs the access and pulses done (and err when out of range).
module data_mem_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_we, w_we_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [DATA_W-1:0] r_rdata;
  logic              w_load;
  logic              w_mem_we;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Full-width compare so addresses past DEPTH never alias onto real words.
  assign w_in_range = ({1'b0, r_addr} < DEPTH_L);
  assign w_idx      = r_addr[IDX_W-1:0];

  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;
  assign rdata = r_rdata;

  // State, request latch and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_we    <= w_we_nxt;
      r_wdata <= w_wdata_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and access-strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_we_nxt    = r_we;
    w_wdata_nxt = r_wdata;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_addr_nxt  = addr;
          w_we_nxt    = we;
          w_wdata_nxt = wdata;
          w_cnt_nxt   = 4'(WAIT_CYCLES);
          w_state_nxt = ST_ACCESS;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_err_nxt   = ~w_in_range;
          w_mem_we    = r_we & w_in_range;
          w_load      = ~r_we & w_in_range;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Load result register; holds until the next successful load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_load) begin
      r_rdata <= r_mem[w_idx];
    end else begin
      r_rdata <= r_rdata;
    end
  end

  // Storage array, deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl: two instances (DEPTH 256 and 128) driven in
// lockstep and compared per transaction against array-based reference models.
module tb_data_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req, we;
  logic [7:0] addr, wdata;
  logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [7:0] rdata_a, rdata_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_mem_a [256];
  logic [7:0] m_mem_b [128];
  logic [7:0] m_rd_a, m_rd_b;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy_a), .done(done_a), .err(err_a), .rdata(rdata_a)
  );

  data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy_b), .done(done_b), .err(err_b), .rdata(rdata_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one completed request on both memories.
  task automatic model_access(input logic t_we, input logic [7:0] t_addr, input logic [7:0] t_wdata);
    if (t_we) m_mem_a[t_addr] = t_wdata;
    else      m_rd_a = m_mem_a[t_addr];
    if (t_addr < 8'd128) begin
      if (t_we) m_mem_b[t_addr[6:0]] = t_wdata;
      else      m_rd_b = m_mem_b[t_addr[6:0]];
    end
  endtask

  // One request, starting in a cycle where the DUT is idle; returns in the done cycle.
  task automatic txn(input logic t_we, input logic [7:0] t_addr, input logic [7:0] t_wdata,
                     input bit t_hold, input string tag);
    bit got;
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
    @(posedge clk); #1;
    check_eq({tag, "_busy_a"}, {31'd0, busy_a}, 32'd1);
    check_eq({tag, "_busy_b"}, {31'd0, busy_b}, 32'd1);
    if (t_hold) begin
      addr = t_addr ^ 8'h30; we = ~t_we; wdata = ~t_wdata;
    end else begin
      req = 1'b0;
    end
    model_access(t_we, t_addr, t_wdata);
    got = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (done_a) begin
        check_eq({tag, "_latency"}, k, 32'd2);
        got = 1'b1;
        break;
      end
    end
    if (!got) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    check_eq({tag, "_done_b"}, {31'd0, done_b}, 32'd1);
    check_eq({tag, "_busy_a_clr"}, {31'd0, busy_a}, 32'd0);
    check_eq({tag, "_err_a"}, {31'd0, err_a}, 32'd0);
    check_eq({tag, "_err_b"}, {31'd0, err_b}, {31'd0, (t_addr >= 8'd128)});
    check_eq({tag, "_rdata_a"}, {24'd0, rdata_a}, {24'd0, m_rd_a});
    check_eq({tag, "_rdata_b"}, {24'd0, rdata_b}, {24'd0, m_rd_b});
    req = 1'b0;
  endtask

  task automatic idle(input string tag);
    req = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_idle_done_a"}, {31'd0, done_a}, 32'd0);
    check_eq({tag, "_idle_done_b"}, {31'd0, done_b}, 32'd0);
    check_eq({tag, "_idle_err_b"}, {31'd0, err_b}, 32'd0);
    check_eq({tag, "_idle_busy_a"}, {31'd0, busy_a}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00;
    m_rd_a = 8'h00; m_rd_b = 8'h00;
    #1;
    check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
    check_eq("rst_done", {31'd0, done_a}, 32'd0);
    check_eq("rst_rdata_a", {24'd0, rdata_a}, 32'd0);
    check_eq("rst_rdata_b", {24'd0, rdata_b}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload every address so all later loads have a known value.
    for (int a = 0; a < 256; a++) begin
      txn(1'b1, 8'(a), 8'($urandom_range(0, 255)), 1'b0, "fill");
    end
    idle("fill");

    txn(1'b1, 8'h10, 8'h5A, 1'b0, "st_5a");
    idle("st_5a");
    txn(1'b0, 8'h10, 8'h00, 1'b0, "ld_5a");
    check_eq("ld_5a_value", {24'd0, rdata_a}, 32'h5A);
    idle("ld_5a");

    txn(1'b0, 8'h10, 8'h00, 1'b1, "hold");
    idle("hold");
    txn(1'b0, 8'h20, 8'h00, 1'b0, "ld_20");
    idle("ld_20");

    txn(1'b1, 8'h01, 8'h33, 1'b0, "b2b_st");
    txn(1'b0, 8'h01, 8'h00, 1'b0, "b2b_ld");
    check_eq("b2b_value", {24'd0, rdata_b}, 32'h33);
    idle("b2b");

    txn(1'b1, 8'h80, 8'hFF, 1'b0, "oor_st");
    idle("oor_st");
    txn(1'b0, 8'h00, 8'h00, 1'b0, "oor_ld0");
    txn(1'b0, 8'h80, 8'h00, 1'b0, "oor_ld80");
    idle("oor");

    txn(1'b1, 8'h05, 8'h00, 1'b0, "pre05");
    txn(1'b0, 8'h01, 8'h00, 1'b0, "pre_ld01");
    req = 1'b1; we = 1'b1; addr = 8'h05; wdata = 8'h77;
    @(posedge clk); #1;
    req = 1'b0;
    check_eq("abort_busy", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy_clr", {31'd0, busy_a}, 32'd0);
    check_eq("abort_done", {31'd0, done_a}, 32'd0);
    check_eq("abort_err", {31'd0, err_b}, 32'd0);
    check_eq("abort_rdata_a", {24'd0, rdata_a}, 32'd0);
    check_eq("abort_rdata_b", {24'd0, rdata_b}, 32'd0);
    m_rd_a = 8'h00; m_rd_b = 8'h00;
    @(negedge clk) rst_n = 1'b1;
    idle("abort");
    idle("abort2");
    txn(1'b0, 8'h05, 8'h00, 1'b0, "abort_ld05");
    check_eq("abort_ld05_value", {24'd0, rdata_a}, 32'h00);
    idle("abort_ld05");

    for (int i = 0; i < 300; i++) begin
      logic       r_we;
      logic [7:0] r_addr;
      r_we   = 1'($urandom_range(0, 1));
      r_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      txn(r_we, r_addr, 8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0), "rnd");
      if ($urandom_range(0, 2) == 0) idle("rnd");
    end
    idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
